// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared types and constants for the P7 hazard/stall controller: MD FSM states,
// Tuse/CP0 constants and the RAW comparator used for each operand/stage pair.
package hazard_stall_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MULT = 2'd1,
    ST_DIV  = 2'd2
  } md_state_e;

  localparam logic [1:0] TUSE_NONE   = 2'd3;
  localparam logic [4:0] CP0_EPC_IDX = 5'd14;
  localparam logic       MD_MULT     = 1'b0;
  localparam logic       MD_DIV      = 1'b1;

  // A D-stage source conflicts with a producer that will not have its value
  // ready in time; $0 and unused operands never conflict.
  function automatic logic raw_hit(input logic [4:0] src,
                                   input logic [1:0] tuse,
                                   input logic [4:0] dst,
                                   input logic       we,
                                   input logic [1:0] tnew);
    return (src != 5'd0) && (tuse != TUSE_NONE) && we && (dst == src) && (tuse < tnew);
  endfunction

endpackage

// File: rtl/hazard_stall_ctrl_md_busy_counter.sv
// Mult/div occupancy tracker: IDLE/MULT/DIV FSM with a 4-bit countdown of the
// busy cycles that follow a start.
module md_busy_counter
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic Clk,
  input  logic Reset,
  input  logic start,
  input  logic req,
  input  logic md_type,
  output logic md_busy
);

  if (MULT_CYCLES > 15 || MULT_CYCLES == 0) begin : g_bad_mult
    $error("MULT_CYCLES must be in 1..15");
  end
  if (DIV_CYCLES > 15 || DIV_CYCLES == 0) begin : g_bad_div
    $error("DIV_CYCLES must be in 1..15");
  end

  md_state_e  state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       go;

  // A start alongside an exception belongs to a flushed instruction.
  assign go = start && !req;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (go) begin
          state_d = (md_type == MD_DIV) ? ST_DIV : ST_MULT;
          cnt_d   = (md_type == MD_DIV) ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
        end
      end
      ST_MULT, ST_DIV: begin
        if (cnt_q == 4'd1) begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    // NOTE: state flops use non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    if (Reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign md_busy = start || (state_q != ST_IDLE);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// P7 pipeline hazard controller: RAW (Tuse/Tnew), mult/div busy and ERET/EPC
// hazards combined with the CP0 request into Stall, DE_Clr and Flush.
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [4:0] D_rs,
  input  logic [4:0] D_rt,
  input  logic [1:0] D_Tuse_rs,
  input  logic [1:0] D_Tuse_rt,
  input  logic [4:0] E_RegDst,
  input  logic       E_RegWrite,
  input  logic [1:0] E_Tnew,
  input  logic [4:0] M_RegDst,
  input  logic       M_RegWrite,
  input  logic [1:0] M_Tnew,
  input  logic       D_isMD,
  input  logic       E_MDStart,
  input  logic       E_MDType,
  input  logic       D_isEret,
  input  logic       E_isMtc0EPC,
  input  logic       M_isMtc0EPC,
  input  logic       Req,
  output logic       Stall,
  output logic       DE_Clr,
  output logic       Flush,
  output logic       MD_Busy
);

  logic md_busy_raw;
  logic raw_stall, md_stall, epc_stall, hazard;

  md_busy_counter #(
    .MULT_CYCLES(MULT_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_md_busy_counter (
    .Clk    (Clk),
    .Reset  (Reset),
    .start  (E_MDStart),
    .req    (Req),
    .md_type(E_MDType),
    .md_busy(md_busy_raw)
  );

  assign raw_stall = raw_hit(D_rs, D_Tuse_rs, E_RegDst, E_RegWrite, E_Tnew)
                  || raw_hit(D_rs, D_Tuse_rs, M_RegDst, M_RegWrite, M_Tnew)
                  || raw_hit(D_rt, D_Tuse_rt, E_RegDst, E_RegWrite, E_Tnew)
                  || raw_hit(D_rt, D_Tuse_rt, M_RegDst, M_RegWrite, M_Tnew);

  assign md_stall  = D_isMD && md_busy_raw;
  assign epc_stall = D_isEret && (E_isMtc0EPC || M_isMtc0EPC);
  assign hazard    = raw_stall || md_stall || epc_stall;

  // Reset forces every control quiet in the same cycle; Req outranks hazards.
  always_comb begin
    Stall   = 1'b0;
    DE_Clr  = 1'b0;
    Flush   = 1'b0;
    MD_Busy = 1'b0;
    if (!Reset) begin
      Stall   = hazard && !Req;
      DE_Clr  = (hazard && !Req) || Req;
      Flush   = Req;
      MD_Busy = md_busy_raw;
    end
  end

endmodule
